pa_core: RTL and testbench

// - Minimal 2-wide in-order VLIW core. It has an internal instruction cache, 32x16-bit register file, borrow/carry flag and PC.
// - Each cycle it fetches one 60-bit bundle (slot A = bits[59:30], slot B = bits[29:0]), executes both slots and writes back.
// - Top of the PA architecture; the cache is programmed through a write port while the core stalls.

---
 rtl/pa_core.sv | 126 ++++++++++++
 tb/tb_pa_core.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pa_core.sv
// pa_core: minimal 2-wide in-order VLIW core with an internal instruction cache,
// a 16-bit register file, a carry/borrow flag and a bundle-indexed PC.
module pa_core #(
  parameter int unsigned BUNDLE_W     = 60,
  parameter int unsigned ICACHE_DEPTH = 32,
  parameter int unsigned NUM_REGS     = 32
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                icacheWriteEnable_i,
  input  logic [15:0]         writeAddress_i,
  input  logic [BUNDLE_W-1:0] instruction_i,
  output logic [15:0]         PC_o,
  output logic                wbAArith_o,
  output logic [4:0]          wbAddrAFinal_o,
  output logic [15:0]         wbValAFinal_o
);

  localparam int unsigned CacheAw = $clog2(ICACHE_DEPTH);

  localparam logic [6:0] OpAdd = 7'b0000001;
  localparam logic [6:0] OpSub = 7'b0000010;
  localparam logic [6:0] OpAnd = 7'b0000011;
  localparam logic [6:0] OpOr  = 7'b0000100;
  localparam logic [6:0] OpXor = 7'b0000101;
  localparam logic [6:0] OpBr  = 7'b0000110;
  localparam logic [6:0] OpLi  = 7'b0001010;

  typedef struct packed {
    logic        we;    // writes rA
    logic        fe;    // updates the flag
    logic        flag;
    logic [15:0] val;
  } slot_res_t;

  logic [BUNDLE_W-1:0] r_icache [ICACHE_DEPTH];
  logic [15:0]         r_regs   [NUM_REGS];
  logic [15:0]         r_pc;
  logic                r_flag;
  logic                r_wb_arith;
  logic [4:0]          r_wb_addr;
  logic [15:0]         r_wb_val;

  logic [BUNDLE_W-1:0] w_bundle;
  logic [29:0]         w_ins_a;
  logic [29:0]         w_ins_b;
  logic [4:0]          w_ra_a;
  logic [4:0]          w_ra_b;
  slot_res_t           w_res_a;
  slot_res_t           w_res_b;
  logic                w_br_taken;
  logic [15:0]         w_pc_next;
  logic                w_unused;

  // Execute one slot against pre-bundle register values.
  function automatic slot_res_t exec_slot(input logic [29:0] ins, input logic [15:0] a,
                                          input logic [15:0] rb_val);
    slot_res_t   res;
    logic [15:0] b;
    logic [16:0] sum;
    res = '0;
    b   = ins[29] ? ins[15:0] : rb_val;
    sum = {1'b0, a} + {1'b0, b};
    case (ins[27:21])
      OpAdd: res = '{we: 1'b1, fe: 1'b1, flag: sum[16], val: sum[15:0]};
      OpSub: res = '{we: 1'b1, fe: 1'b1, flag: (a < b), val: a - b};
      OpAnd: res = '{we: 1'b1, fe: 1'b0, flag: 1'b0, val: a & b};
      OpOr:  res = '{we: 1'b1, fe: 1'b0, flag: 1'b0, val: a | b};
      OpXor: res = '{we: 1'b1, fe: 1'b0, flag: 1'b0, val: a ^ b};
      OpLi:  res = '{we: 1'b1, fe: 1'b0, flag: 1'b0, val: ins[15:0]};
      default: res = '0;  // NOP, BR and unknown opcodes write nothing
    endcase
    return res;
  endfunction

  // Fetch, decode both slots and resolve the branch in slot A.
  always_comb begin
    w_bundle   = r_icache[r_pc[CacheAw-1:0]];
    w_ins_a    = w_bundle[59:30];
    w_ins_b    = w_bundle[29:0];
    w_ra_a     = w_ins_a[20:16];
    w_ra_b     = w_ins_b[20:16];
    w_res_a    = exec_slot(w_ins_a, r_regs[w_ra_a], r_regs[w_ins_a[15:11]]);
    w_res_b    = exec_slot(w_ins_b, r_regs[w_ra_b], r_regs[w_ins_b[15:11]]);
    w_br_taken = (w_ins_a[27:21] == OpBr) && (!w_ins_a[28] || r_flag);
    w_pc_next  = w_br_taken ? (r_pc + r_regs[w_ra_a]) : (r_pc + 16'd1);
  end

  assign w_unused = ^writeAddress_i[15:CacheAw];

  // Cache write port; contents survive reset.
  always_ff @(posedge clock_i) begin
    if (icacheWriteEnable_i) begin
      r_icache[writeAddress_i[CacheAw-1:0]] <= instruction_i;
    end
  end

  // Architectural state and slot A writeback; slot B is applied last so it wins conflicts.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
      r_pc       <= '0;
      r_flag     <= 1'b0;
      r_wb_arith <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_val   <= '0;
    end else if (icacheWriteEnable_i) begin
      r_wb_arith <= 1'b0;
    end else begin
      if (w_res_a.we) r_regs[w_ra_a] <= w_res_a.val;
      if (w_res_b.we) r_regs[w_ra_b] <= w_res_b.val;
      if (w_res_b.fe)      r_flag <= w_res_b.flag;
      else if (w_res_a.fe) r_flag <= w_res_a.flag;
      r_pc       <= w_pc_next;
      r_wb_arith <= w_res_a.we;
      r_wb_addr  <= w_res_a.we ? w_ra_a : 5'd0;
      r_wb_val   <= w_res_a.we ? w_res_a.val : 16'd0;
    end
  end

  assign PC_o           = r_pc;
  assign wbAArith_o     = r_wb_arith;
  assign wbAddrAFinal_o = r_wb_addr;
  assign wbValAFinal_o  = r_wb_val;

endmodule

// File: tb/tb_pa_core.sv
// Directed self-checking bench for pa_core.
module tb_pa_core;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [15:0] waddr;
  logic [59:0] instr;
  logic [15:0] pc;
  logic        wb_arith;
  logic [4:0]  wb_addr;
  logic [15:0] wb_val;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [6:0] NOP = 7'd0, ADD = 7'd1, SUB = 7'd2, XOR = 7'd5, BR = 7'd6, LI = 7'd10;

  pa_core dut (
    .clock_i            (clk),
    .reset_i            (rst_n),
    .icacheWriteEnable_i(we),
    .writeAddress_i     (waddr),
    .instruction_i      (instr),
    .PC_o               (pc),
    .wbAArith_o         (wb_arith),
    .wbAddrAFinal_o     (wb_addr),
    .wbValAFinal_o      (wb_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] enc_r(input logic c, input logic [6:0] op,
                                        input logic [4:0] ra, input logic [4:0] rb);
    return {1'b0, c, op, ra, rb, 11'd0};
  endfunction

  function automatic logic [29:0] enc_i(input logic [6:0] op, input logic [4:0] ra,
                                        input logic [15:0] imm);
    return {1'b1, 1'b0, op, ra, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [59:0] d);
    we    = 1'b1;
    waddr = a;
    instr = d;
    step();
  endtask

  task automatic chk_wb(input string tag, input logic [4:0] addr, input logic [15:0] val,
                        input logic [15:0] exp_pc);
    chk({tag, "_arith"}, {31'd0, wb_arith}, 32'd1);
    chk({tag, "_addr"}, {27'd0, wb_addr}, {27'd0, addr});
    chk({tag, "_val"}, {16'd0, wb_val}, {16'd0, val});
    chk({tag, "_pc"}, {16'd0, pc}, {16'd0, exp_pc});
  endtask

  task automatic chk_nowb(input string tag, input logic [15:0] exp_pc);
    chk({tag, "_arith"}, {31'd0, wb_arith}, 32'd0);
    chk({tag, "_pc"}, {16'd0, pc}, {16'd0, exp_pc});
  endtask

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    waddr = '0;
    instr = '0;
    #2;
    // Clear the cache to NOP bundles while held in reset.
    for (int i = 0; i < 32; i++) wr(16'(i), 60'd0);
    we = 1'b0;
    chk_nowb("in_reset", 16'd0);
    chk("in_reset_val", {16'd0, wb_val}, 32'd0);

    // Empty cache: PC free-runs 0..20 with no writeback.
    rst_n = 1'b1;
    chk_nowb("release", 16'd0);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk_nowb("nop_run", 16'(i));
    end

    // Program the cache while stalled.
    wr(16'd0,  {enc_i(LI, 5'd1, 16'd10), enc_i(LI, 5'd2, 16'd5)});
    wr(16'd1,  {enc_r(1'b0, SUB, 5'd2, 5'd1), enc_i(LI, 5'd2, 16'd5)});
    wr(16'd2,  {enc_r(1'b0, SUB, 5'd1, 5'd2), 30'd0});
    wr(16'd3,  {enc_i(LI, 5'd3, 16'd15), enc_i(LI, 5'd7, 16'hFFFE)});
    wr(16'd4,  {enc_r(1'b1, BR, 5'd3, 5'd0), 30'd0});
    wr(16'd5,  {enc_r(1'b0, SUB, 5'd6, 5'd3), 30'd0});
    wr(16'd6,  {enc_r(1'b0, BR, 5'd7, 5'd0), 30'd0});
    wr(16'd19, {enc_i(LI, 5'd4, 16'd1), enc_i(LI, 5'd4, 16'd2)});
    wr(16'd20, {enc_r(1'b0, ADD, 5'd5, 5'd4), 30'd0});
    wr(16'd21, {enc_r(1'b0, NOP, 5'd0, 5'd0), enc_r(1'b0, BR, 5'd3, 5'd0)});
    wr(16'd22, {enc_r(1'b0, XOR, 5'd3, 5'd2), 30'd0});
    we = 1'b0;
    chk_nowb("prog_stall", 16'd20);

    // Async reset between edges.
    #3 rst_n = 1'b0;
    #1 chk_nowb("async_rst", 16'd0);
    #1 rst_n = 1'b1;

    step(); chk_wb("li", 5'd1, 16'd10, 16'd1);
    step(); chk_wb("sub_borrow", 5'd2, 16'hFFFB, 16'd2);
    step(); chk_wb("sub_noborrow", 5'd1, 16'd5, 16'd3);
    step(); chk_wb("li_r3", 5'd3, 16'd15, 16'd4);
    step(); chk_nowb("br_c1_flag0", 16'd5);
    step(); chk_wb("sub_setflag", 5'd6, 16'hFFF1, 16'd6);
    step(); chk_nowb("br_uncond_wrap", 16'd4);
    step(); chk_nowb("br_c1_flag1", 16'd19);
    step(); chk_wb("dual_write", 5'd4, 16'd1, 16'd20);
    step(); chk_wb("add_r4", 5'd5, 16'd2, 16'd21);
    step(); chk_nowb("br_slot_b", 16'd22);
    step(); chk_wb("xor", 5'd3, 16'd10, 16'd23);

    // Stall mid-run for 3 edges; last write to 23 must be the one fetched.
    wr(16'd23, {enc_i(LI, 5'd9, 16'h5555), 30'd0});
    chk_nowb("stall1", 16'd23);
    wr(16'd24, {enc_r(1'b0, ADD, 5'd9, 5'd9), 30'd0});
    chk_nowb("stall2", 16'd23);
    wr(16'd23, {enc_i(LI, 5'd9, 16'h1234), 30'd0});
    chk_nowb("stall3", 16'd23);
    we = 1'b0;
    step(); chk_wb("after_stall", 5'd9, 16'h1234, 16'd24);
    step(); chk_wb("add_self", 5'd9, 16'h2468, 16'd25);

    // Reset again: state clears, cache keeps its program.
    #3 rst_n = 1'b0;
    #1 chk_nowb("async_rst2", 16'd0);
    chk("async_rst2_val", {16'd0, wb_val}, 32'd0);
    #1 rst_n = 1'b1;
    step(); chk_wb("rerun_li", 5'd1, 16'd10, 16'd1);
    step(); chk_wb("rerun_sub", 5'd2, 16'hFFFB, 16'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
